// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder. The WIDTH-bit operands are split into
// GROUP-bit lookahead groups; stage k resolves group k and registers its group
// carry-out, which becomes the carry-in of stage k+1. The pipeline advances as
// one unit with valid/ready flow control, giving one add per cycle.
//
// Parameters:
//   WIDTH  operand/sum width, must be a multiple of GROUP
//   GROUP  bits per lookahead group (STAGES = WIDTH/GROUP)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle (= !out_valid || out_ready)
//   in_a/in_b  operands
//   in_cin     carry-in
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_sum    (A + B + cin) mod 2^WIDTH
//   out_cout   carry out of bit WIDTH-1
//   out_ovf    signed overflow (only when CLA_OVF_EN is defined)
//
// Build option:
//   CLA_OVF_EN  adds the out_ovf port and a register for the carry into the MSB
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef CLA_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned STAGES = (GROUP > 0) ? (WIDTH / GROUP) : 1;

   if (GROUP < 1) begin : g_bad_group
      $error("cla_pipe_adder: GROUP must be at least 1");
   end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end

   // Group adder: every carry is a flat sum-of-products of g/p and cin,
   // so no carry depends on another carry inside the group.
   // Returns {group carry-out, group sum}.
   function automatic logic [GROUP:0] cla_group(
      input logic [GROUP-1:0] a,
      input logic [GROUP-1:0] b,
      input logic             cin
   );
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   c;
      logic             term;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < GROUP; i++) begin
         term = cin;
         for (int unsigned m = 0; m <= i; m++) term = term & p[m];
         c[i+1] = term;
         for (int unsigned j = 0; j <= i; j++) begin
            term = g[j];
            for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[GROUP], p ^ c[GROUP-1:0]};
   endfunction

   // Stage registers
   logic [STAGES-1:0] valid_q, valid_d;
   logic [WIDTH-1:0]  a_q     [STAGES];
   logic [WIDTH-1:0]  a_d     [STAGES];
   logic [WIDTH-1:0]  b_q     [STAGES];
   logic [WIDTH-1:0]  b_d     [STAGES];
   logic [WIDTH-1:0]  sum_q   [STAGES];
   logic [WIDTH-1:0]  sum_d   [STAGES];
   logic [STAGES-1:0] carry_q, carry_d;

   logic              adv;
   logic [GROUP:0]    grp;

   always_comb begin
      adv     = !valid_q[STAGES-1] || out_ready;
      grp     = '0;
      valid_d = valid_q;
      carry_d = carry_q;
      for (int unsigned k = 0; k < STAGES; k++) begin
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
      end

      if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
               valid_d[0] = in_valid;
               // operands are only sampled on acceptance
               if (in_valid) begin
                  grp                    = cla_group(in_a[GROUP-1:0], in_b[GROUP-1:0], in_cin);
                  a_d[0]                 = in_a;
                  b_d[0]                 = in_b;
                  sum_d[0]               = '0;
                  sum_d[0][GROUP-1:0]    = grp[GROUP-1:0];
                  carry_d[0]             = grp[GROUP];
               end
            end else begin
               valid_d[k] = valid_q[k-1];
               // bubbles advance without disturbing the data registers
               if (valid_q[k-1]) begin
                  grp                       = cla_group(a_q[k-1][k*GROUP +: GROUP],
                                                        b_q[k-1][k*GROUP +: GROUP],
                                                        carry_q[k-1]);
                  a_d[k]                    = a_q[k-1];
                  b_d[k]                    = b_q[k-1];
                  sum_d[k]                  = sum_q[k-1];
                  sum_d[k][k*GROUP +: GROUP] = grp[GROUP-1:0];
                  carry_d[k]                = grp[GROUP];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

`ifdef CLA_OVF_EN
   // Carry into the MSB recovered as sum ^ a ^ b at bit WIDTH-1; it tracks
   // the last-stage registers so it loads and holds in step with them.
   logic cmsb_q, cmsb_d;

   always_comb begin
      cmsb_d = sum_d[STAGES-1][WIDTH-1] ^ a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cmsb_q <= 1'b0;
      else        cmsb_q <= cmsb_d;
   end

   assign out_ovf = cmsb_q ^ carry_q[STAGES-1];
`endif

   assign in_ready  = adv;
   assign out_valid = valid_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_cout  = carry_q[STAGES-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Directed testbench for cla_pipe_adder: a 16/4 instance (four stages) and a
// 4/4 instance (single stage). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   // 16-bit, 4-stage instance
   logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
   logic [15:0] in_a, in_b, out_sum;
`ifdef CLA_OVF_EN
   logic        out_ovf;
   logic        v4_out_ovf;
`endif

   // 4-bit, single-stage instance
   logic        v4_in_valid, v4_in_ready, v4_in_cin, v4_out_valid, v4_out_ready, v4_out_cout;
   logic [3:0]  v4_in_a, v4_in_b, v4_out_sum;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CLA_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   cla_pipe_adder #(.WIDTH(4), .GROUP(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v4_in_valid),
      .in_ready  (v4_in_ready),
      .in_a      (v4_in_a),
      .in_b      (v4_in_b),
      .in_cin    (v4_in_cin),
      .out_valid (v4_out_valid),
      .out_ready (v4_out_ready),
      .out_sum   (v4_out_sum),
      .out_cout  (v4_out_cout)
`ifdef CLA_OVF_EN
      ,
      .out_ovf   (v4_out_ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction on the 16-bit instance, output always ready.
   task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_cin    = cin;
      #1;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_lat"}, n, 4);
      check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
      step();
   endtask

   // Stream vectors: a, b, cin, expected sum, expected cout
   logic [15:0] sa [8];
   logic [15:0] sb [8];
   logic        sc [8];
   logic [15:0] ss [8];
   logic        so [8];

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int          i, j, c, seen;
      logic [15:0] held;

      sa = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h7FFF, 16'hC000, 16'h00FF};
      sb = '{16'h1111, 16'hFFFF, 16'h8000, 16'h00F1, 16'h1234, 16'h0001, 16'h4000, 16'h0000};
      sc = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
      ss = '{16'h2345, 16'hFFFF, 16'h0000, 16'h1000, 16'hBE02, 16'h8000, 16'h0000, 16'h0100};
      so = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_a         = '0;
      in_b         = '0;
      in_cin       = 1'b0;
      out_ready    = 1'b1;
      v4_in_valid  = 1'b0;
      v4_in_a      = '0;
      v4_in_b      = '0;
      v4_in_cin    = 1'b0;
      v4_out_ready = 1'b1;

      // ---- reset state
      step();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_cout", 32'(out_cout), 32'd0);
      check("rst_v4_valid", 32'(v4_out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(in_ready), 32'd1);
      step();

      // ---- basic and cross-group carry chains
      send16("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
`ifdef CLA_OVF_EN
      check("zero_ovf", 32'(out_ovf), 32'd0);
`endif
      send16("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      send16("5555_aaaa", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1);
      send16("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef CLA_OVF_EN
      check("7fff_p1_ovf", 32'(out_ovf), 32'd1);
`endif
      send16("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
`ifdef CLA_OVF_EN
      check("8000_8000_ovf", 32'(out_ovf), 32'd1);
`endif

      // ---- single-stage instance
      v4_in_valid = 1'b1;
      v4_in_a     = 4'b1010;
      v4_in_b     = 4'b0101;
      v4_in_cin   = 1'b1;
      step();
      v4_in_a     = 4'b1111;
      v4_in_b     = 4'b1111;
      v4_in_cin   = 1'b0;
      check("v4_a_valid", 32'(v4_out_valid), 32'd1);
      check("v4_a_sum", 32'(v4_out_sum), 32'd0);
      check("v4_a_cout", 32'(v4_out_cout), 32'd1);
      step();
      v4_in_valid = 1'b0;
      check("v4_b_valid", 32'(v4_out_valid), 32'd1);
      check("v4_b_sum", 32'(v4_out_sum), 32'hE);
      check("v4_b_cout", 32'(v4_out_cout), 32'd1);
      step();
      check("v4_idle", 32'(v4_out_valid), 32'd0);

      // ---- back-to-back stream with a 3-cycle stall on cycles 5..7
      i    = 0;
      j    = 0;
      c    = 0;
      held = '0;
      while (j < 8 && c < 60) begin
         out_ready = !(c >= 5 && c <= 7);
         if (i < 8) begin
            in_valid = 1'b1;
            in_a     = sa[i];
            in_b     = sb[i];
            in_cin   = sc[i];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check($sformatf("stream_rdy_c%0d", c), 32'(in_ready), (c >= 5 && c <= 7) ? 32'd0 : 32'd1);
         if (c >= 5 && c <= 7) begin
            check($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("stall_sum_c%0d", c), 32'(out_sum), 32'(ss[j]));
            if (c == 5) held = out_sum;
            else        check($sformatf("stall_hold_c%0d", c), 32'(out_sum), 32'(held));
         end
         if (out_valid && out_ready) begin
            check($sformatf("stream_sum_%0d", j), 32'(out_sum), 32'(ss[j]));
            check($sformatf("stream_cout_%0d", j), 32'(out_cout), 32'(so[j]));
            j++;
         end
         if (in_valid && in_ready) i++;
         step();
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", j, 8);
      step();
      step();

      // ---- reset with three transactions in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0;
      step();
      in_a = 16'hF000; in_b = 16'h1000; in_cin = 1'b0;
      step();
      in_a = 16'h0001; in_b = 16'h0002; in_cin = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_sum", 32'(out_sum), 32'h2222);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(out_sum), 32'd0);
      check("mid_rst_cout", 32'(out_cout), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      seen      = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (out_valid) seen++;
      end
      check("rst_flush", seen, 0);
      send16("post_rst", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder: WIDTH-bit operands split into GROUP-bit lookahead groups, one group resolved per pipeline stage, with a registered carry passed between stages. Successor to the combinational 4-bit CLA. Adds a real carry-in, width generalisation, full throughput (one add per cycle) and valid/ready flow control, so it can sit directly on the datapath streaming interfaces.

## Interface
- WIDTH, 16: operand and sum width. Must be a multiple of GROUP.
- GROUP, 4: bits per lookahead group. STAGES = WIDTH/GROUP.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept the input this cycle.
- in_a  input  WIDTH  operand A, unsigned/two's complement.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  signed overflow. Present only with CLA_OVF_EN.

## Operation
- Stage k (k = 0..STAGES-1) computes group k (bits k*GROUP .. k*GROUP+GROUP-1).
  - Per bit: g = a&b, p = a^b.
  - Group carries come from lookahead equations on g/p and the incoming stage carry. No ripple inside a group.
- Each stage registers:
  - its valid bit;
  - the sum bits resolved so far;
  - the operand bits not yet consumed;
  - the group carry-out, used as the next stage's carry-in.
- Stage 0 uses in_cin as its carry-in. The last stage's carry-out is out_cout.
- Global advance: adv = !out_valid || out_ready.
  - When adv = 1, all stages shift together; stage 0 loads valid = in_valid.
  - When adv = 0, every stage register holds its value.
- in_ready = adv, a combinational function of out_valid and out_ready.
- Bubbles are not collapsed. An invalid slot still occupies a stage.
- Results leave in acceptance order. No loss, no duplication.

## Timing
- Reset (rst_n low, asynchronous):
  - all stage valid bits = 0;
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0;
  - in_ready = 1 once reset is released, since out_valid = 0.
- Reset mid-operation discards every in-flight transaction. No result from before reset ever appears.
- Latency: operands accepted at edge t (in_valid && in_ready) produce out_valid = 1 after edge t+STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready = 1.
- Output stability: while out_valid && !out_ready, out_sum, out_cout and out_ovf hold stable, and in_ready = 0.
- Simultaneous out_ready = 1 and in_valid = 1 with a full pipe: the result is consumed and the new operand is accepted on the same edge.
- in_a, in_b and in_cin are sampled only when in_valid && in_ready.
- WIDTH == GROUP (STAGES = 1): latency is 1 cycle, and the arithmetic matches the 4-bit CLA.
- Elaboration must fail if WIDTH % GROUP != 0 or GROUP < 1.

## Configuration
- CLA_OVF_EN defined:
  - the out_ovf port exists;
  - the last stage also registers the carry into bit WIDTH-1;
  - out_ovf = carry into MSB XOR out_cout;
  - out_ovf is valid alongside out_valid, and its reset value is 0.
- CLA_OVF_EN undefined:
  - no out_ovf port and no extra register;
  - all other behaviour is identical.

## Test plan
- Defaults, 0x0000 + 0x0000, cin=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance; out_sum=0x0000, out_cout=0.
- Cross-group carry chains:
  - 0xFFFF + 0x0001, cin=0 -> out_sum=0x0000, out_cout=1.
  - 0x5555 + 0xAAAA, cin=1 -> out_sum=0x0000, out_cout=1.
- Back-to-back stream of 8 random vectors, with out_ready low for 3 cycles mid-stream:
  - in_ready is low exactly during the stall;
  - the output is held stable during the stall;
  - all 8 results are correct and in order.
- Reset mid-stream: assert rst_n low with 3 transactions in flight -> outputs go to 0 immediately; none of those results appear after release.
- WIDTH=4, GROUP=4, single-stage latency:
  - 1010 + 0101, cin=1 -> out_sum=0000, out_cout=1 after 1 cycle;
  - 1111 + 1111, cin=0 -> out_sum=1110, out_cout=1.
- CLA_OVF_EN, defaults:
  - 0x7FFF + 0x0001 -> out_sum=0x8000, out_ovf=1, out_cout=0;
  - 0x8000 + 0x8000 -> out_sum=0x0000, out_ovf=1, out_cout=1.
